// File: rtl/ring_pkg.sv
// Shared widths, packet layout and slot-decision encoding for the force-writeback ring.
package ring_pkg;

   localparam int NUM_CELLS         = 64;
   localparam int DATA_WIDTH        = 32;
   localparam int PARTICLE_ID_WIDTH = 7;
   localparam int NODE_ID_WIDTH     = $clog2(NUM_CELLS);
   localparam int FORCE_DATA_WIDTH  = 3*DATA_WIDTH + PARTICLE_ID_WIDTH;
   localparam int PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH;

   typedef struct packed {
      logic [NODE_ID_WIDTH-1:0]     dst;
      logic [PARTICLE_ID_WIDTH-1:0] particle_id;
      logic [DATA_WIDTH-1:0]        fz;
      logic [DATA_WIDTH-1:0]        fy;
      logic [DATA_WIDTH-1:0]        fx;
   } packet_t;

   typedef enum logic [2:0] {
      SLOT_EJECT,
      SLOT_TRANSIT,
      SLOT_INJECT,
      SLOT_SELF,
      SLOT_IDLE
   } slot_t;

   function automatic logic [NODE_ID_WIDTH-1:0] get_dst(input packet_t p);
      return p.dst;
   endfunction

endpackage

// File: rtl/ring_node_if.sv
// Local injection, ring hop and ejection signals of one ring stop.
interface ring_node_if #(
   parameter int PACKET_WIDTH     = ring_pkg::PACKET_WIDTH,
   parameter int FORCE_DATA_WIDTH = ring_pkg::FORCE_DATA_WIDTH
);
   logic [PACKET_WIDTH-1:0]     packet_in;
   logic                        packet_valid;
   logic                        ready;
   logic [PACKET_WIDTH-1:0]     ring_in_data;
   logic                        ring_in_valid;
   logic [PACKET_WIDTH-1:0]     ring_out_data;
   logic                        ring_out_valid;
   logic [FORCE_DATA_WIDTH-1:0] data_out;
   logic                        data_valid;
   logic                        inj_empty;
   logic                        bad_dst;

   modport master (
      output packet_in, packet_valid, ring_in_data, ring_in_valid,
      input  ready, ring_out_data, ring_out_valid, data_out, data_valid,
             inj_empty, bad_dst
   );

   modport slave (
      input  packet_in, packet_valid, ring_in_data, ring_in_valid,
      output ready, ring_out_data, ring_out_valid, data_out, data_valid,
             inj_empty, bad_dst
   );
endinterface

// File: rtl/ring_inject_fifo.sv
// Show-ahead synchronous FIFO holding local packets waiting for a free ring slot.
module ring_inject_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ring_node.sv
// One stop of the bufferless force-writeback ring: eject, transit, inject or self-deliver each cycle.
module ring_node #(
   parameter int NUM_CELLS         = 64,
   parameter int DATA_WIDTH        = 32,
   parameter int PARTICLE_ID_WIDTH = 7,
   parameter int NODE_ID           = 0,
   parameter int FIFO_DEPTH        = 4,
   parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
   parameter int FORCE_DATA_WIDTH  = 3*DATA_WIDTH + PARTICLE_ID_WIDTH,
   parameter int PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   ring_node_if.slave  bus
);
   import ring_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [NODE_ID_WIDTH-1:0] MY_ID = NODE_ID_WIDTH'(NODE_ID);

   logic [PACKET_WIDTH-1:0]     head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [CNT_W-1:0]            fifo_count;
   logic                        push;
   logic                        pop;

   logic [NODE_ID_WIDTH-1:0]    ring_dst;
   logic [NODE_ID_WIDTH-1:0]    head_dst;
   logic [NODE_ID_WIDTH-1:0]    in_dst;
   logic                        ring_bad;
   logic                        head_bad;
   logic                        in_bad;
   logic                        ring_eject;
   slot_t                       slot_sel;
   slot_t                       eject_sel;

   logic [PACKET_WIDTH-1:0]     ring_out_data_q;
   logic                        ring_out_valid_q;
   logic [FORCE_DATA_WIDTH-1:0] data_out_q;
   logic                        data_valid_q;
   logic                        bad_dst_q;

   assign push = bus.packet_valid & ~fifo_full;

   ring_inject_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PACKET_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (bus.packet_in),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign ring_dst = bus.ring_in_data[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
   assign head_dst = head[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
   assign in_dst   = bus.packet_in[PACKET_WIDTH-1 -: NODE_ID_WIDTH];

   // A full power-of-two ring has no out-of-range destination encodings.
   generate
      if (NUM_CELLS == (1 << NODE_ID_WIDTH)) begin : g_no_limit
         assign ring_bad = 1'b0;
         assign head_bad = 1'b0;
         assign in_bad   = 1'b0;
      end else begin : g_limit
         localparam logic [NODE_ID_WIDTH-1:0] LIMIT = NODE_ID_WIDTH'(NUM_CELLS);
         assign ring_bad = (ring_dst >= LIMIT);
         assign head_bad = (head_dst >= LIMIT);
         assign in_bad   = (in_dst   >= LIMIT);
      end
   endgenerate

   // A bad-destination ring packet still occupies the slot; it just isn't forwarded.
   always_comb begin
      slot_sel   = SLOT_IDLE;
      eject_sel  = SLOT_IDLE;
      pop        = 1'b0;
      ring_eject = bus.ring_in_valid & ~ring_bad & (ring_dst == MY_ID);
      if (ring_eject)
         eject_sel = SLOT_EJECT;
      else if (bus.ring_in_valid & ~ring_bad)
         slot_sel = SLOT_TRANSIT;
      if (!fifo_empty) begin
         if (head_bad) begin
            pop = 1'b1;
         end else if (head_dst == MY_ID) begin
            if (!ring_eject) begin
               eject_sel = SLOT_SELF;
               pop       = 1'b1;
            end
         end else if (!bus.ring_in_valid || ring_eject) begin
            slot_sel = SLOT_INJECT;
            pop      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ring_out_data_q  <= '0;
         ring_out_valid_q <= 1'b0;
         data_out_q       <= '0;
         data_valid_q     <= 1'b0;
         bad_dst_q        <= 1'b0;
      end else begin
         ring_out_valid_q <= (slot_sel != SLOT_IDLE);
         if (slot_sel == SLOT_TRANSIT)
            ring_out_data_q <= bus.ring_in_data;
         else if (slot_sel == SLOT_INJECT)
            ring_out_data_q <= head;
         data_valid_q <= (eject_sel != SLOT_IDLE);
         if (eject_sel == SLOT_EJECT)
            data_out_q <= bus.ring_in_data[FORCE_DATA_WIDTH-1:0];
         else if (eject_sel == SLOT_SELF)
            data_out_q <= head[FORCE_DATA_WIDTH-1:0];
         bad_dst_q <= bad_dst_q | (bus.ring_in_valid & ring_bad) | (push & in_bad);
      end
   end

   assign bus.ready          = (fifo_count != CNT_W'(FIFO_DEPTH));
   assign bus.inj_empty      = fifo_empty & ~data_valid_q;
   assign bus.ring_out_data  = ring_out_data_q;
   assign bus.ring_out_valid = ring_out_valid_q;
   assign bus.data_out       = data_out_q;
   assign bus.data_valid     = data_valid_q;
   assign bus.bad_dst        = bad_dst_q;

endmodule

// File: tb/tb_ring_node.sv
// Directed bench for ring_node: node 5 on a 64-stop ring and node 5 on a 6-stop ring.
module tb_ring_node;
   import ring_pkg::*;

   localparam int FDW  = ring_pkg::FORCE_DATA_WIDTH;
   localparam int PW_A = ring_pkg::PACKET_WIDTH;
   localparam int PW_B = FDW + 3;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   ring_node_if #(.PACKET_WIDTH(PW_A), .FORCE_DATA_WIDTH(FDW)) bus_a ();
   ring_node_if #(.PACKET_WIDTH(PW_B), .FORCE_DATA_WIDTH(FDW)) bus_b ();

   ring_node #(.NUM_CELLS(64), .NODE_ID(5), .FIFO_DEPTH(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   ring_node #(.NUM_CELLS(6), .NODE_ID(5), .FIFO_DEPTH(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW_A-1:0] mk_a(input int dst, input int pid, input logic [31:0] fx);
      return {6'(dst), 7'(pid), fx + 32'd2, fx + 32'd1, fx};
   endfunction

   function automatic logic [PW_B-1:0] mk_b(input int dst, input int pid, input logic [31:0] fx);
      return {3'(dst), 7'(pid), fx + 32'd2, fx + 32'd1, fx};
   endfunction

   logic [PW_A-1:0] exp_a;
   logic [PW_A-1:0] lpk [4];
   logic [PW_A-1:0] tpk [3];
   packet_t         pk;

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b0;
      bus_a.packet_in = '0; bus_a.packet_valid = 1'b0;
      bus_a.ring_in_data = '0; bus_a.ring_in_valid = 1'b0;
      bus_b.packet_in = '0; bus_b.packet_valid = 1'b0;
      bus_b.ring_in_data = '0; bus_b.ring_in_valid = 1'b0;
      #12;
      chk("rst_rov", bus_a.ring_out_valid, 0);
      chk("rst_dv", bus_a.data_valid, 0);
      chk("rst_ready", bus_a.ready, 1);
      chk("rst_inj_empty", bus_a.inj_empty, 1);
      chk("rst_bad", bus_a.bad_dst, 0);
      chk("rst_rod", bus_a.ring_out_data, 0);
      @(negedge clk); rst = 1'b1;
      step();

      // transit
      exp_a = mk_a(9, 0, 32'hABC);
      bus_a.ring_in_data = exp_a; bus_a.ring_in_valid = 1'b1;
      step();
      chk("tr_rov", bus_a.ring_out_valid, 1);
      chk("tr_data", bus_a.ring_out_data, exp_a);
      pk = packet_t'(bus_a.ring_out_data);
      chk("tr_dst", get_dst(pk), 9);
      chk("tr_dv", bus_a.data_valid, 0);

      // ejection
      exp_a = mk_a(5, 17, 32'h123);
      bus_a.ring_in_data = exp_a;
      step();
      chk("ej_dv", bus_a.data_valid, 1);
      chk("ej_pid", bus_a.data_out[FDW-1 -: 7], 17);
      chk("ej_data", bus_a.data_out, exp_a[FDW-1:0]);
      chk("ej_rov", bus_a.ring_out_valid, 0);
      bus_a.ring_in_valid = 1'b0;
      step();
      chk("ej_dv_off", bus_a.data_valid, 0);
      chk("ej_inj_empty", bus_a.inj_empty, 1);

      // injection under contention
      for (int i = 0; i < 4; i++) lpk[i] = mk_a(6, 100 + i, 32'h1000 + 32'(16 * i));
      for (int i = 0; i < 3; i++) tpk[i] = mk_a(9, 50 + i, 32'h2000 + 32'(i));
      bus_a.packet_in = lpk[0]; bus_a.packet_valid = 1'b1;
      step();
      chk("ct_rov_pre", bus_a.ring_out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         bus_a.packet_in = lpk[i+1];
         bus_a.ring_in_data = tpk[i]; bus_a.ring_in_valid = 1'b1;
         step();
         chk("ct_tr_rov", bus_a.ring_out_valid, 1);
         chk("ct_tr_data", bus_a.ring_out_data, tpk[i]);
      end
      chk("ct_full_ready", bus_a.ready, 0);
      chk("ct_full_inj_empty", bus_a.inj_empty, 0);
      bus_a.packet_valid = 1'b0; bus_a.ring_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ct_inj_rov", bus_a.ring_out_valid, 1);
         chk("ct_inj_data", bus_a.ring_out_data, lpk[i]);
         if (i == 0) chk("ct_ready_back", bus_a.ready, 1);
      end
      step();
      chk("ct_done_rov", bus_a.ring_out_valid, 0);
      chk("ct_done_inj_empty", bus_a.inj_empty, 1);

      // self-delivery blocked by ring ejection
      bus_a.packet_in = mk_a(5, 40, 32'h4000); bus_a.packet_valid = 1'b1;
      step();
      bus_a.packet_valid = 1'b0;
      chk("sc_push_dv", bus_a.data_valid, 0);
      bus_a.ring_in_data = mk_a(5, 41, 32'h5000); bus_a.ring_in_valid = 1'b1;
      step();
      chk("sc_ring_dv", bus_a.data_valid, 1);
      chk("sc_ring_pid", bus_a.data_out[FDW-1 -: 7], 41);
      chk("sc_ring_inj_empty", bus_a.inj_empty, 0);
      bus_a.ring_in_valid = 1'b0;
      step();
      chk("sc_self_dv", bus_a.data_valid, 1);
      chk("sc_self_pid", bus_a.data_out[FDW-1 -: 7], 40);
      chk("sc_self_rov", bus_a.ring_out_valid, 0);
      step();
      chk("sc_end_dv", bus_a.data_valid, 0);
      chk("sc_end_inj_empty", bus_a.inj_empty, 1);

      // reset mid-stream: transit and self-delivery both in flight
      bus_a.packet_in = mk_a(5, 60, 32'h6000); bus_a.packet_valid = 1'b1;
      bus_a.ring_in_data = mk_a(9, 61, 32'h6100); bus_a.ring_in_valid = 1'b1;
      step();
      bus_a.packet_valid = 1'b0;
      step();
      chk("mr_rov_pre", bus_a.ring_out_valid, 1);
      chk("mr_dv_pre", bus_a.data_valid, 1);
      #2; rst = 1'b0; #1;
      chk("mr_rov", bus_a.ring_out_valid, 0);
      chk("mr_dv", bus_a.data_valid, 0);
      chk("mr_ready", bus_a.ready, 1);
      chk("mr_inj_empty", bus_a.inj_empty, 1);
      bus_a.ring_in_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      step();

      // 6-stop ring: good transit, then out-of-range ring packet
      bus_b.ring_in_data = mk_b(3, 7, 32'h77); bus_b.ring_in_valid = 1'b1;
      step();
      chk("b_tr_rov", bus_b.ring_out_valid, 1);
      chk("b_tr_data", bus_b.ring_out_data, mk_b(3, 7, 32'h77));
      chk("b_tr_bad", bus_b.bad_dst, 0);
      bus_b.ring_in_data = mk_b(7, 8, 32'h88);
      step();
      chk("b_bad_set", bus_b.bad_dst, 1);
      chk("b_bad_rov", bus_b.ring_out_valid, 0);
      chk("b_bad_dv", bus_b.data_valid, 0);
      bus_b.ring_in_valid = 1'b0;
      step(); step();
      chk("b_bad_sticky", bus_b.bad_dst, 1);
      chk("b_bad_rov2", bus_b.ring_out_valid, 0);

      // out-of-range local packet is flagged and dropped at the head
      @(negedge clk); rst = 1'b0;
      #1;
      chk("b_rst_bad", bus_b.bad_dst, 0);
      @(negedge clk); rst = 1'b1;
      step();
      bus_b.packet_in = mk_b(6, 9, 32'h99); bus_b.packet_valid = 1'b1;
      step();
      bus_b.packet_valid = 1'b0;
      chk("b_loc_bad", bus_b.bad_dst, 1);
      chk("b_loc_inj_empty0", bus_b.inj_empty, 0);
      step();
      chk("b_loc_drop_inj_empty", bus_b.inj_empty, 1);
      chk("b_loc_drop_rov", bus_b.ring_out_valid, 0);
      chk("b_loc_drop_dv", bus_b.data_valid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
